// File: rtl/uart_multi_ctrl.sv
// UART-controlled multi-channel pattern generator: 8N1 byte receiver, 8-byte
// command frame parser and CH_NUM independent bit-pattern sequencers.
`timescale 1ns/1ps

module uart_multi_ctrl #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int CH_NUM   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    output logic [CH_NUM-1:0] signal,
    output logic              cmd_valid,
    output logic              cmd_err
);

    localparam int BIT_DIV = CLK_FREQ / BAUD;
    localparam int CNT_W   = $clog2(BIT_DIV + 1);

    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(BIT_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [7:0]       CH_LIMIT  = 8'(CH_NUM);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [2:0] {
        P_HDR0 = 3'd0,
        P_HDR1 = 3'd1,
        P_CH   = 3'd2,
        P_CTRL = 3'd3,
        P_T3   = 3'd4,
        P_T2   = 3'd5,
        P_T1   = 3'd6,
        P_T0   = 3'd7
    } p_state_t;

    logic             sync1_r;
    logic             sync2_r;
    logic             rx_prev_r;
    logic             fall_s;

    rx_state_t        rx_state_r;
    rx_state_t        rx_state_s;
    logic [CNT_W-1:0] baud_cnt_r;
    logic [CNT_W-1:0] baud_cnt_s;
    logic [2:0]       bit_idx_r;
    logic [2:0]       bit_idx_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_s;
    logic             byte_stb_s;
    logic             byte_stb_r;
    logic             stop_err_s;
    logic             stop_err_r;

    p_state_t         p_state_r;
    p_state_t         p_state_s;
    logic [7:0]       frm_ch_r;
    logic [7:0]       frm_ch_s;
    logic [7:0]       frm_ctrl_r;
    logic [7:0]       frm_ctrl_s;
    logic [31:0]      frm_time_r;
    logic [31:0]      frm_time_s;
    logic             load_s;
    logic             err_s;

    // Two-flop synchronizer plus delayed copy for start-edge detection; idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r   <= 1'b1;
            sync2_r   <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            sync1_r   <= uart_rx;
            sync2_r   <= sync1_r;
            rx_prev_r <= sync2_r;
        end
    end

    assign fall_s = rx_prev_r & ~sync2_r;

    // Receiver next-state: start bit checked at mid-bit, data and stop one bit apart.
    always_comb begin
        rx_state_s = rx_state_r;
        baud_cnt_s = baud_cnt_r;
        bit_idx_s  = bit_idx_r;
        shift_s    = shift_r;
        byte_stb_s = 1'b0;
        stop_err_s = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                baud_cnt_s = CNT_ZERO;
                if (fall_s) begin
                    rx_state_s = RX_START;
                end else begin
                    rx_state_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (baud_cnt_r == HALF_LAST) begin
                    baud_cnt_s = CNT_ZERO;
                    bit_idx_s  = 3'd0;
                    rx_state_s = sync2_r ? RX_IDLE : RX_DATA;
                end else begin
                    baud_cnt_s = baud_cnt_r + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (baud_cnt_r == DIV_LAST) begin
                    baud_cnt_s = CNT_ZERO;
                    shift_s    = {sync2_r, shift_r[7:1]};
                    bit_idx_s  = bit_idx_r + 3'd1;
                    if (bit_idx_r == 3'd7) begin
                        rx_state_s = RX_STOP;
                    end else begin
                        rx_state_s = RX_DATA;
                    end
                end else begin
                    baud_cnt_s = baud_cnt_r + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (baud_cnt_r == DIV_LAST) begin
                    baud_cnt_s = CNT_ZERO;
                    rx_state_s = RX_IDLE;
                    if (sync2_r) begin
                        byte_stb_s = 1'b1;
                    end else begin
                        stop_err_s = 1'b1;
                    end
                end else begin
                    baud_cnt_s = baud_cnt_r + CNT_ONE;
                end
            end
            default: begin
                rx_state_s = RX_IDLE;
                baud_cnt_s = CNT_ZERO;
            end
        endcase
    end

    // Receiver state register; byte and stop-error strobes are registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_r <= RX_IDLE;
            baud_cnt_r <= CNT_ZERO;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
            byte_stb_r <= 1'b0;
            stop_err_r <= 1'b0;
        end else begin
            rx_state_r <= rx_state_s;
            baud_cnt_r <= baud_cnt_s;
            bit_idx_r  <= bit_idx_s;
            shift_r    <= shift_s;
            byte_stb_r <= byte_stb_s;
            stop_err_r <= stop_err_s;
        end
    end

    // Frame parser next-state; shift_r stays stable while byte_stb_r is high.
    always_comb begin
        p_state_s  = p_state_r;
        frm_ch_s   = frm_ch_r;
        frm_ctrl_s = frm_ctrl_r;
        frm_time_s = frm_time_r;
        load_s     = 1'b0;
        err_s      = 1'b0;
        if (stop_err_r) begin
            p_state_s = P_HDR0;
            err_s     = 1'b1;
        end else if (byte_stb_r) begin
            case (p_state_r)
                P_HDR0: begin
                    if (shift_r == 8'h55) begin
                        p_state_s = P_HDR1;
                    end else begin
                        p_state_s = P_HDR0;
                    end
                end
                P_HDR1: begin
                    if (shift_r == 8'hA5) begin
                        p_state_s = P_CH;
                    end else if (shift_r == 8'h55) begin
                        p_state_s = P_HDR1;
                    end else begin
                        p_state_s = P_HDR0;
                    end
                end
                P_CH: begin
                    frm_ch_s  = shift_r;
                    p_state_s = P_CTRL;
                end
                P_CTRL: begin
                    frm_ctrl_s = shift_r;
                    p_state_s  = P_T3;
                end
                P_T3: begin
                    frm_time_s = {24'h000000, shift_r};
                    p_state_s  = P_T2;
                end
                P_T2: begin
                    frm_time_s = {frm_time_r[23:0], shift_r};
                    p_state_s  = P_T1;
                end
                P_T1: begin
                    frm_time_s = {frm_time_r[23:0], shift_r};
                    p_state_s  = P_T0;
                end
                P_T0: begin
                    frm_time_s = {frm_time_r[23:0], shift_r};
                    p_state_s  = P_HDR0;
                    if (frm_ch_r < CH_LIMIT) begin
                        load_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end
                default: begin
                    p_state_s = P_HDR0;
                end
            endcase
        end else begin
            p_state_s = p_state_r;
        end
    end

    // Parser state, frame fields and registered command status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_state_r  <= P_HDR0;
            frm_ch_r   <= 8'h00;
            frm_ctrl_r <= 8'h00;
            frm_time_r <= 32'h00000000;
            cmd_valid  <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            p_state_r  <= p_state_s;
            frm_ch_r   <= frm_ch_s;
            frm_ctrl_r <= frm_ctrl_s;
            frm_time_r <= frm_time_s;
            cmd_valid  <= load_s;
            cmd_err    <= err_s;
        end
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        logic [7:0]  ch_ctrl_r;
        logic [31:0] ch_time_r;
        logic [31:0] ch_cnt_r;
        logic [2:0]  ch_idx_r;
        logic        ch_sig_r;
        logic        hit_s;

        assign hit_s     = load_s && (frm_ch_r == 8'(g));
        assign signal[g] = ch_sig_r;

        // Pattern sequencer: output follows ctrl[idx] one cycle late, each bit held time cycles.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                ch_ctrl_r <= 8'h00;
                ch_time_r <= 32'h00000000;
                ch_cnt_r  <= 32'h00000000;
                ch_idx_r  <= 3'd0;
                ch_sig_r  <= 1'b0;
            end else begin
                ch_sig_r <= (ch_time_r != 32'h00000000) ? ch_ctrl_r[ch_idx_r] : 1'b0;
                if (hit_s) begin
                    ch_ctrl_r <= frm_ctrl_r;
                    ch_time_r <= frm_time_s;
                    ch_cnt_r  <= 32'h00000000;
                    ch_idx_r  <= 3'd0;
                end else if (ch_time_r != 32'h00000000) begin
                    if (ch_cnt_r == ch_time_r - 32'h00000001) begin
                        ch_cnt_r <= 32'h00000000;
                        ch_idx_r <= ch_idx_r + 3'd1;
                    end else begin
                        ch_cnt_r <= ch_cnt_r + 32'h00000001;
                    end
                end else begin
                    ch_cnt_r <= 32'h00000000;
                    ch_idx_r <= 3'd0;
                end
            end
        end
    end

endmodule
